hilo_div_sequencer: RTL and testbench

//  Iterative divide sequencer and HI/LO register owner for the Minisys-1A EX stage.

---
 rtl/hilo_div_sequencer.sv | 164 ++++++++++++++++
 tb/tb_hilo_div_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer
//   Iterative divide sequencer and owner of the HI/LO registers for the EX stage.
//   Runs a one-bit-per-cycle restoring divide for DIV/DIVU. Interlocks MFHI/MFLO/MTHI/MTLO
//   and a new DIV against an in-flight divide via a combinational stall. A flush aborts
//   the divide without touching HI/LO.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        DIV/DIVU issued in EX
//   is_unsigned_i  1 = DIVU, 0 = DIV
//   dividend_i     rs value
//   divisor_i      rt value
//   mthi_i/mtlo_i  MTHI/MTLO in EX, writing mt_data_i
//   mt_data_i      rs value for MTHI/MTLO
//   mfhi_i/mflo_i  MFHI/MFLO in EX
//   flush_i        exception/ERET flush, highest priority
//   busy_o         divide in progress
//   stall_o        hold the pipeline (combinational)
//   hi_o/lo_o      HI (remainder) / LO (quotient)
//   mf_data_o      hi_o if mfhi_i, else lo_o (combinational)
//   done_o         one-cycle pulse after HI/LO are written by a divide
//   div_zero_o     one-cycle pulse after a divide by zero was rejected
module hilo_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_unsigned_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] mt_data_i,
  input  logic             mfhi_i,
  input  logic             mflo_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] rem_q;     // partial remainder
  logic [WIDTH-1:0] quo_q;     // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0] dvs_q;     // |divisor|
  logic             q_neg_q, r_neg_q;
  logic [CntW-1:0]  cnt_q;
  logic             done_q, div_zero_q;

  // Operand magnitudes; only DIV treats the MSB as a sign.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    a_neg = ~is_unsigned_i & dividend_i[WIDTH-1];
    b_neg = ~is_unsigned_i & divisor_i[WIDTH-1];
    a_abs = a_neg ? (~dividend_i + WIDTH'(1)) : dividend_i;
    b_abs = b_neg ? (~divisor_i + WIDTH'(1)) : divisor_i;
  end

  // One restoring step. rem_q < divisor always, so WIDTH+1 bits hold the shifted value
  // and the MSB of the difference is a clean borrow.
  logic [WIDTH:0]   rem_shift, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    q_bit     = ~diff[WIDTH];
    rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], q_bit};
  end

  // Sign correction. 0x80000000 / -1 wraps back to 0x80000000 naturally.
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    q_fix = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (flush_i) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              // start wins over a simultaneous MTHI/MTLO
              if (divisor_i == '0) begin
                div_zero_q <= 1'b1;
              end else begin
                rem_q   <= '0;
                quo_q   <= a_abs;
                dvs_q   <= b_abs;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                cnt_q   <= '0;
                state_q <= StCalc;
              end
            end else begin
              if (mthi_i) hi_q <= mt_data_i;
              if (mtlo_i) lo_q <= mt_data_i;
            end
          end
          StCalc: begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (cnt_q == CntLast) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StFix: begin
            hi_q    <= r_fix;
            lo_q    <= q_fix;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy_o     = (state_q != StIdle);
  // Requests arriving while busy are dropped; the pipeline re-presents them.
  assign stall_o    = busy_o & (start_i | mthi_i | mtlo_i | mfhi_i | mflo_i);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign mf_data_o  = mfhi_i ? hi_q : lo_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Directed self-checking bench for hilo_div_sequencer.
module tb_hilo_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_unsigned, mthi, mtlo, mfhi, mflo, flush;
  logic [31:0] dividend, divisor, mt_data;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo, mf_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hilo_div_sequencer #(.WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .is_unsigned_i (is_unsigned),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .mthi_i        (mthi),
    .mtlo_i        (mtlo),
    .mt_data_i     (mt_data),
    .mfhi_i        (mfhi),
    .mflo_i        (mflo),
    .flush_i       (flush),
    .busy_o        (busy),
    .stall_o       (stall),
    .hi_o          (hi),
    .lo_o          (lo),
    .mf_data_o     (mf_data),
    .done_o        (done),
    .div_zero_o    (div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and wait (bounded) until busy drops; returns the busy cycle count.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                        output int cyc);
    dividend    = a;
    divisor     = b;
    is_unsigned = uns;
    start       = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (busy && cyc < 50) begin
      cyc++;
      tick();
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; mtlo = 1'b0; mt_data = h; tick();
    mthi = 1'b0; mtlo = 1'b1; mt_data = l; tick();
    mtlo = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy, done, div_zero, stall} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, stall});
    end
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_divu_basic();
    int cyc;
    do_div(32'd100, 32'd7, 1'b1, cyc);
    n_tests++;
    if (cyc !== 33) begin n_fail++; $display("FAIL divu_busy_len: got %0d want 33", cyc); end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL divu_done: got %b want 1", done); end
    n_tests++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++; $display("FAIL divu_100_7: got lo=%h hi=%h want 0000000e/00000002", lo, hi);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL divu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div_signed();
    int cyc;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
    n_tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_m7_2: got lo=%h hi=%h want fffffffd/ffffffff", lo, hi);
    end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b0, cyc);
    n_tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      n_fail++; $display("FAIL div_7_m2: got lo=%h hi=%h want fffffffd/00000001", lo, hi);
    end
  endtask

  task automatic test_boundaries();
    int cyc;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    n_tests++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      n_fail++; $display("FAIL div_overflow: got lo=%h hi=%h want 80000000/00000000", lo, hi);
    end
    do_div(32'hFFFF_FFFF, 32'd1, 1'b1, cyc);
    n_tests++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd0) begin
      n_fail++; $display("FAIL divu_max_1: got lo=%h hi=%h want ffffffff/00000000", lo, hi);
    end
  endtask

  task automatic test_interlock();
    int          cyc;
    int          bad;
    logic [31:0] hi_mid;
    set_hilo(32'h77, 32'h88);
    dividend = 32'd50; divisor = 32'd8; is_unsigned = 1'b1; start = 1'b1;
    tick();
    start   = 1'b0;
    mfhi    = 1'b1;
    mt_data = 32'hDEAD;
    cyc = 0; bad = 0; hi_mid = 32'h0;
    while (busy && cyc < 50) begin
      #1;
      if (stall !== 1'b1) bad++;
      mthi = (cyc >= 3 && cyc < 6);
      if (cyc == 8) hi_mid = hi;
      cyc++;
      tick();
    end
    mthi = 1'b0;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_while_busy: got %0d low cycles want 0", bad); end
    n_tests++;
    if (hi_mid !== 32'h77) begin
      n_fail++; $display("FAIL mthi_ignored_busy: got %h want 00000077", hi_mid);
    end
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got stall=%b done=%b want 0/1", stall, done);
    end
    n_tests++;
    if (mf_data !== 32'd2) begin n_fail++; $display("FAIL mfhi_data: got %h want 00000002", mf_data); end
    mfhi = 1'b0; mflo = 1'b1;
    #1;
    n_tests++;
    if (mf_data !== 32'd6) begin n_fail++; $display("FAIL mflo_data: got %h want 00000006", mf_data); end
    mflo = 1'b0;
    tick();
    mtlo = 1'b1; mt_data = 32'h1234;
    tick();
    mtlo = 1'b0;
    n_tests++;
    if (lo !== 32'h1234 || hi !== 32'd2) begin
      n_fail++; $display("FAIL mtlo_idle: got lo=%h hi=%h want 00001234/00000002", lo, hi);
    end
  endtask

  task automatic test_start_priority();
    int cyc;
    dividend = 32'd9; divisor = 32'd3; is_unsigned = 1'b1;
    start = 1'b1; mthi = 1'b1; mt_data = 32'hAA;
    tick();
    start = 1'b0; mthi = 1'b0;
    n_tests++;
    if (hi !== 32'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_beats_mthi: got hi=%h busy=%b want 00000002/1", hi, busy);
    end
    cyc = 0;
    while (busy && cyc < 50) begin cyc++; tick(); end
    n_tests++;
    if (lo !== 32'd3 || hi !== 32'd0) begin
      n_fail++; $display("FAIL divu_9_3: got lo=%h hi=%h want 00000003/00000000", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    set_hilo(32'd5, 32'd6);
    dividend = 32'd123; divisor = 32'd0; is_unsigned = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (div_zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL divzero_pulse: got dz=%b busy=%b done=%b want 1/0/0",
                         div_zero, busy, done);
    end
    tick();
    n_tests++;
    if (div_zero !== 1'b0 || busy !== 1'b0 || hi !== 32'd5 || lo !== 32'd6) begin
      n_fail++; $display("FAIL divzero_after: got dz=%b busy=%b hi=%h lo=%h want 0/0/5/6",
                         div_zero, busy, hi, lo);
    end
  endtask

  task automatic test_flush();
    int dones;
    set_hilo(32'hA, 32'hB);
    dividend = 32'd1000; divisor = 32'd3; is_unsigned = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || hi !== 32'hA || lo !== 32'hB) begin
      n_fail++; $display("FAIL flush_abort: got busy=%b hi=%h lo=%h want 0/a/b", busy, hi, lo);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    // flush together with start in IDLE: start is dropped
    flush = 1'b1; start = 1'b1; divisor = 32'd5;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start: got busy=%b want 0", busy); end
    divisor = 32'd0;
    tick();
    flush = 1'b0; start = 1'b0;
    n_tests++;
    if (div_zero !== 1'b0) begin n_fail++; $display("FAIL flush_divzero: got %b want 0", div_zero); end
  endtask

  task automatic test_reset_mid();
    set_hilo(32'h55, 32'h66);
    dividend = 32'd77; divisor = 32'd4; is_unsigned = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2;
    do_div(32'd100, 32'd7, 1'b1, cyc1);
    n_tests++;
    if (lo !== 32'd14 || hi !== 32'd2 || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got lo=%h hi=%h done=%b want e/2/1", lo, hi, done);
    end
    do_div(32'hFFFF_FFEC, 32'd3, 1'b0, cyc2);
    n_tests++;
    if (cyc2 !== 33 || lo !== 32'hFFFF_FFFA || hi !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL b2b_second: got cyc=%0d lo=%h hi=%h want 33/fffffffa/fffffffe",
                         cyc2, lo, hi);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; is_unsigned = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    flush = 1'b0; dividend = '0; divisor = '0; mt_data = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_divu_basic();
    test_div_signed();
    test_boundaries();
    test_interlock();
    test_start_priority();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
